timer: RTL and testbench

TIMER -- requirements
Module: timer

---
 rtl/timer_pkg.sv | 23 ++
 rtl/tick_divider.sv | 50 +++++
 rtl/timer.sv | 52 +++++
 tb/tb_timer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Platform timing constants shared by the timer block, plus
//                a helper that sizes a divider counter for a given period.
//                CLOCK_SPEED is the input clock rate in Hz; CPU_SPEED is the
//                CPU instruction tick rate in Hz.
//  Revision    : 1.0  initial release
// ============================================================================
package timer_pkg;

    localparam int c_CLOCK_SPEED = 100000;
    localparam int c_CPU_SPEED   = 500;
    localparam int c_SLOW_RATE   = 60;

    // Counter width for a modulo-PERIOD counter; never narrower than 1 bit so
    // that a PERIOD of 1 still has a legal (constant-zero) register.
    function automatic int count_width(input int period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

endpackage : timer_pkg
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tick_divider
//  Description : Free-running modulo-PERIOD counter producing a one-cycle
//                tick whenever the count is zero. The count powers up at zero,
//                so the block works with or without a reset ever applied.
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset; forces count to 0 and
//                       masks the tick while asserted
//                tick - combinational pulse, high for one cycle per PERIOD
//  Revision    : 1.0  initial release
// ============================================================================
module tick_divider
    import timer_pkg::*;
#(
    parameter int PERIOD = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int                 c_WIDTH = count_width(PERIOD);
    localparam logic [c_WIDTH-1:0] c_LAST  = c_WIDTH'(PERIOD - 1);
    localparam logic [c_WIDTH-1:0] c_ONE   = c_WIDTH'(1);

    if (PERIOD < 1) begin : g_bad_period
        $error("tick_divider: PERIOD must be at least 1");
    end

    // Declaration initialiser gives the power-up value without needing rst.
    logic [c_WIDTH-1:0] r_count = '0;

    // With PERIOD = 1 c_LAST is 0, so the wrap branch holds the count at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_ONE;
        end
    end

    // Gated with rst so the first cycle after release (count already 0)
    // reports the tick, while reset cycles report nothing.
    assign tick = (r_count == '0) && !rst;

endmodule : tick_divider
`default_nettype wire

// File: rtl/timer.sv
`default_nettype none
// ============================================================================
//  Module      : timer
//  Description : Derives two independent tick streams from the system clock:
//                a CPU instruction tick at CPU_SPEED Hz and a 60 Hz tick for
//                the delay and sound timers. Both dividers restart together
//                on reset, so both ticks assert on the first free cycle.
//  Ports       : clk             - rising-edge clock (CLOCK_SPEED Hz)
//                rst             - synchronous active-high reset
//                timer_cpu_tick  - one-cycle pulse at CPU_SPEED Hz
//                timer_60hz_tick - one-cycle pulse at 60 Hz
//  Revision    : 1.0  initial release
// ============================================================================
module timer
    import timer_pkg::*;
#(
    parameter int CLOCK_SPEED = c_CLOCK_SPEED,
    parameter int CPU_SPEED   = c_CPU_SPEED
) (
    input  logic clk,
    input  logic rst,
    output logic timer_cpu_tick,
    output logic timer_60hz_tick
);

    // Truncating division: the tick rate rounds up slightly when the clock
    // is not an exact multiple, with no drift correction.
    localparam int c_PER_CPU = CLOCK_SPEED / CPU_SPEED;
    localparam int c_PER_60  = CLOCK_SPEED / c_SLOW_RATE;

    if (c_PER_CPU < 1 || c_PER_60 < 1) begin : g_bad_rates
        $error("timer: CLOCK_SPEED too low for the requested tick rates");
    end

    tick_divider #(
        .PERIOD (c_PER_CPU)
    ) u_cpu_div (
        .clk  (clk),
        .rst  (rst),
        .tick (timer_cpu_tick)
    );

    tick_divider #(
        .PERIOD (c_PER_60)
    ) u_60hz_div (
        .clk  (clk),
        .rst  (rst),
        .tick (timer_60hz_tick)
    );

endmodule : timer
`default_nettype wire

// File: tb/tb_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer
//  Description : Scoreboard bench for timer. Three instances share clk/rst:
//                default rates, a 60/60 build (both periods 1) and a
//                1200/100 build (periods 12 and 20, coincident every 60).
//                Expected ticks come from "edges since release mod period".
//  Revision    : 1.0  initial release
// ============================================================================
module tb_timer;

    localparam int c_CYCLES = 6000;

    // Periods derived from the rate definitions, not from the RTL.
    localparam int c_A_CLK = 100000, c_A_CPU = 500;
    localparam int c_B_CLK = 60,     c_B_CPU = 60;
    localparam int c_C_CLK = 1200,   c_C_CPU = 100;
    localparam int c_PER_A_CPU = c_A_CLK / c_A_CPU;
    localparam int c_PER_A_60  = c_A_CLK / 60;
    localparam int c_PER_B_CPU = c_B_CLK / c_B_CPU;
    localparam int c_PER_B_60  = c_B_CLK / 60;
    localparam int c_PER_C_CPU = c_C_CLK / c_C_CPU;
    localparam int c_PER_C_60  = c_C_CLK / 60;

    typedef struct {
        int   cyc;
        logic a_cpu, a_60, b_cpu, b_60, c_cpu, c_60;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic w_a_cpu, w_a_60, w_b_cpu, w_b_60, w_c_cpu, w_c_60;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   stim_done = 1'b0;
    bit   mon_done  = 1'b0;

    timer dut_a (
        .clk             (clk),
        .rst             (rst),
        .timer_cpu_tick  (w_a_cpu),
        .timer_60hz_tick (w_a_60)
    );

    timer #(
        .CLOCK_SPEED (c_B_CLK),
        .CPU_SPEED   (c_B_CPU)
    ) dut_b (
        .clk             (clk),
        .rst             (rst),
        .timer_cpu_tick  (w_b_cpu),
        .timer_60hz_tick (w_b_60)
    );

    timer #(
        .CLOCK_SPEED (c_C_CLK),
        .CPU_SPEED   (c_C_CPU)
    ) dut_c (
        .clk             (clk),
        .rst             (rst),
        .timer_cpu_tick  (w_c_cpu),
        .timer_60hz_tick (w_c_60)
    );

    // No edge before t=10, so the t=5 sample sees the pure power-up state.
    initial begin
        #10;
        forever begin
            clk = 1'b1;
            #5;
            clk = 1'b0;
            #5;
        end
    end

    task automatic check(input string name, input int cyc, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at sample %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    // Stimulus + reference model: n = rising edges since power-up or since
    // the last edge taken with rst high; tick = !rst && (n mod PER == 0).
    initial begin : stimulus
        int   n;
        int   rst_left;
        exp_t e;
        n        = 0;
        rst_left = 0;
        #1;
        for (int k = 0; k < c_CYCLES; k++) begin
            if (k == 137) begin
                rst_left = 3;
            end else if (k > 3600 && rst_left == 0 && $urandom_range(0, 399) == 0) begin
                rst_left = $urandom_range(1, 4);
            end
            rst = (rst_left != 0);
            if (rst_left != 0) rst_left--;

            e.cyc   = k;
            e.a_cpu = !rst && (n % c_PER_A_CPU == 0);
            e.a_60  = !rst && (n % c_PER_A_60  == 0);
            e.b_cpu = !rst && (n % c_PER_B_CPU == 0);
            e.b_60  = !rst && (n % c_PER_B_60  == 0);
            e.c_cpu = !rst && (n % c_PER_C_CPU == 0);
            e.c_60  = !rst && (n % c_PER_C_60  == 0);
            q.push_back(e);

            @(posedge clk);
            #1;
            if (rst) n = 0;
            else     n = n + 1;
        end
        rst       = 1'b0;
        stim_done = 1'b1;
    end

    // Monitor: samples mid-cycle, 4 time units after the stimulus update.
    initial begin : monitor
        exp_t e;
        #5;
        while (!stim_done || q.size() != 0) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty at time %0t: got 0 entries, expected 1", $time);
            end else begin
                e = q.pop_front();
                check("a_cpu_tick",  e.cyc, w_a_cpu, e.a_cpu);
                check("a_60hz_tick", e.cyc, w_a_60,  e.a_60);
                check("b_cpu_tick",  e.cyc, w_b_cpu, e.b_cpu);
                check("b_60hz_tick", e.cyc, w_b_60,  e.b_60);
                check("c_cpu_tick",  e.cyc, w_c_cpu, e.c_cpu);
                check("c_60hz_tick", e.cyc, w_c_60,  e.c_60);
            end
            #10;
        end
        mon_done = 1'b1;
    end

    initial begin : finisher
        wait (mon_done);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #((c_CYCLES + 100) * 10);
        $display("FAIL watchdog: got no completion, expected finish within %0d cycles", c_CYCLES + 100);
        $fatal(1, "timeout");
    end

endmodule : tb_timer
`default_nettype wire
